operand_issue_stage: RTL and testbench
======================================

# operand_issue_stage

Decode/operand-fetch stage directly upstream of the integer ALU. Accepts one 32-bit RV32I instruction per cycle, decodes OP (0x33) and OP-IMM (0x13) formats, reads the 32×32 register file, generates the sign-extended I-immediate, and presents a registered operand bundle to the ALU. A per-register busy scoreboard stalls read-after-write hazards. The write-back port closes the loop from the ALU result back into the register file.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  stage accepts instruction this cycle.
- `in_instr`  in  32  raw instruction word.
- `out_valid`  out  1  operand bundle valid.
- `out_ready`  in  1  ALU side accepts bundle.
- `out_imm`  out  1  1 = immediate form; drives ALU `i_en`.
- `out_funct3`  out  3  instr[14:12].
- `out_funct7`  out  7  instr[31:25].
- `out_rs1`  out  32  rs1 value.
- `out_rs2`  out  32  rs2 value (R-type) or sign-extended instr[31:20] (I-type).
- `out_rd`  out  5  destination register; 0 for illegal.
- `out_illegal`  out  1  opcode not OP/OP-IMM.
- `wb_en`  in  1  write-back strobe.
- `wb_addr`  in  5  write-back register.
- `wb_data`  in  32  write-back value.

## Operation
- Decode: opcode = instr[6:0]. 0x33 → `imm`=0, source rs2 from register file. 0x13 → `imm`=1, rs2 field ignored for hazard check. Other → `illegal`=1, `rd`=0, operands 0, no hazard check, no scoreboard set.
- Immediate: {{20{instr[31]}}, instr[31:20]}; for shifts, bits [11:5] pass through unmodified so the ALU distinguishes SRLI/SRAI.
- Register file: x0 reads 0 always; writes to x0 are ignored. Read is combinational from `in_instr`.
- Write-back bypass: if `wb_en` and `wb_addr`==source (nonzero) in the same cycle as acceptance, captured operand = `wb_data`.
- Scoreboard: 32 busy bits, bit 0 tied 0. Accepting a legal instruction with rd≠0 sets busy[rd]. `wb_en` clears busy[wb_addr]. Same-cycle set and clear of one register: set wins.
- Hazard: source register busy and not cleared by `wb_en` this cycle → stall. rs2 checked only for 0x33. A busy rd alone (WAW) is also a stall.
- `in_ready` = (!`out_valid` || `out_ready`) && !hazard. `in_ready` may depend combinationally on `in_instr` and `wb_*`, never on `in_valid`.

## Timing
- Latency 1: accepted at edge N → bundle valid after edge N.
- Output register loads on `in_valid && in_ready`; `out_valid` clears on `out_ready` without a new acceptance; holds bundle stable while `out_valid && !out_ready`.
- Full throughput: back-to-back independent instructions, one per cycle with `out_ready`=1.
- Dependent back-to-back: second instruction stalls until its source's `wb_en` cycle, accepted in that same cycle with bypassed data.
- Register file write at rising edge when `wb_en`.
- Reset (asynchronous, any time including mid-stall): `out_valid`=0, all other outputs 0, all busy bits 0, register file cleared to 0; `in_ready` returns 1 in the first cycle after deassertion if `out_valid`=0.

## Structure
- Shared package `riscv_pkg`: opcode constants OPC_OP=7'h33, OPC_OP_IMM=7'h13; field-slice localparams; operand bundle struct (imm, funct3, funct7, rs1, rs2, rd, illegal).
- One sub-module: `regfile` (32×32, two combinational read ports, one write port, x0 hard zero, async reset). Scoreboard, decode, bypass, and output register in `operand_issue_stage`.

## Test plan
- Reset, then write x1=5, x2=3 via wb; issue `add x3,x1,x2` (0x002081B3) → next cycle out_valid=1, imm=0, rs1=5, rs2=3, rd=3, funct7=0.
- Issue `srai x4,x1,3` (0x4030D213) → imm=1, funct3=5, rs2=0x00000403, rd=4.
- Issue `add x3,x1,x2` then `sub x5,x3,x1` back-to-back → second held (in_ready=0) until wb_en x3=8 cycle, then accepted with rs1=8.
- Hold out_ready=0 for 3 cycles with out_valid=1 → bundle unchanged, in_ready=0; release → next instruction accepted same cycle.
- Opcode 0x03 (load) → out_illegal=1, rd=0, no busy bit set; write to x0 via wb → x0 still reads 0.
- Assert rst_n=0 mid-stall with busy[3]=1 → out_valid=0 immediately; after release, instruction reading x3 accepted without stall.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions for the integer issue path: opcodes, field
// positions and the operand bundle handed to the ALU.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;

    localparam int OPC_LSB    = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int IMM_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    typedef struct packed {
        logic            imm;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [4:0]      rd;
        logic            illegal;
    } operand_bundle_t;

    // I-immediate; shift-amount encodings keep bits [11:5] so SRLI/SRAI stay distinct
    function automatic logic [XLEN-1:0] sext_i_imm(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:IMM_LSB]};
    endfunction

endpackage

// File: rtl/regfile.sv
// 32 x XLEN integer register file: two combinational read ports, one write
// port, x0 hard-wired to zero, contents cleared by asynchronous reset.
module regfile
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs_r [32];

    // Storage array; x0 is never written so it stays at its reset value of zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? {XLEN{1'b0}} : regs_r[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? {XLEN{1'b0}} : regs_r[rs2_addr];

endmodule

// File: rtl/operand_issue_stage.sv
// Decode / operand-fetch stage ahead of the integer ALU: decodes OP and OP-IMM,
// fetches operands with write-back bypass, and stalls on busy registers.
module operand_issue_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_imm,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_illegal,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data
);

    logic [6:0]      opcode_s;
    logic [4:0]      rs1_addr_s;
    logic [4:0]      rs2_addr_s;
    logic [4:0]      rd_addr_s;
    logic            is_op_s;
    logic            is_op_imm_s;
    logic            legal_s;
    logic [XLEN-1:0] rf_rs1_s;
    logic [XLEN-1:0] rf_rs2_s;
    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;
    logic            hazard_s;
    logic            accept_s;
    logic [31:0]     busy_r;
    logic [31:0]     busy_next_s;
    operand_bundle_t bundle_next_s;
    operand_bundle_t bundle_r;
    logic            out_valid_r;

    assign opcode_s    = in_instr[OPC_LSB +: 7];
    assign rd_addr_s   = in_instr[RD_LSB +: 5];
    assign rs1_addr_s  = in_instr[RS1_LSB +: 5];
    assign rs2_addr_s  = in_instr[RS2_LSB +: 5];
    assign is_op_s     = (opcode_s == OPC_OP);
    assign is_op_imm_s = (opcode_s == OPC_OP_IMM);
    assign legal_s     = is_op_s || is_op_imm_s;

    regfile #(.XLEN(XLEN)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr_s),
        .rs2_addr (rs2_addr_s),
        .rs1_data (rf_rs1_s),
        .rs2_data (rf_rs2_s),
        .we       (wb_en),
        .waddr    (wb_addr),
        .wdata    (wb_data)
    );

    // Same-cycle write-back forwards straight into the captured operands
    always_comb begin
        rs1_val_s = rf_rs1_s;
        rs2_val_s = rf_rs2_s;
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == rs1_addr_s)) begin
            rs1_val_s = wb_data;
        end else begin
            rs1_val_s = rf_rs1_s;
        end
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == rs2_addr_s)) begin
            rs2_val_s = wb_data;
        end else begin
            rs2_val_s = rf_rs2_s;
        end
    end

    // Hazard: a busy source (rs2 only for OP) or busy rd, unless written back this cycle
    always_comb begin
        hazard_s = 1'b0;
        if (legal_s) begin
            hazard_s = (busy_r[rs1_addr_s] && !(wb_en && (wb_addr == rs1_addr_s)))
                    || (is_op_s && busy_r[rs2_addr_s] && !(wb_en && (wb_addr == rs2_addr_s)))
                    || (busy_r[rd_addr_s] && !(wb_en && (wb_addr == rd_addr_s)));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign in_ready = (!out_valid_r || out_ready) && !hazard_s;
    assign accept_s = in_valid && in_ready;

    // Scoreboard update: clear on write-back first so a same-cycle set wins
    always_comb begin
        busy_next_s = busy_r;
        if (wb_en) begin
            busy_next_s[wb_addr] = 1'b0;
        end else begin
            busy_next_s = busy_r;
        end
        if (accept_s && legal_s && (rd_addr_s != 5'd0)) begin
            busy_next_s[rd_addr_s] = 1'b1;
        end else begin
            busy_next_s[0] = 1'b0;
        end
        busy_next_s[0] = 1'b0;
    end

    // Operand bundle assembly; illegal opcodes carry zero operands and rd
    always_comb begin
        bundle_next_s         = '0;
        bundle_next_s.funct3  = in_instr[FUNCT3_LSB +: 3];
        bundle_next_s.funct7  = in_instr[FUNCT7_LSB +: 7];
        if (legal_s) begin
            bundle_next_s.imm     = is_op_imm_s;
            bundle_next_s.rs1     = rs1_val_s;
            bundle_next_s.rs2     = is_op_imm_s ? sext_i_imm(in_instr) : rs2_val_s;
            bundle_next_s.rd      = rd_addr_s;
            bundle_next_s.illegal = 1'b0;
        end else begin
            bundle_next_s.illegal = 1'b1;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Output register: load on acceptance, drop valid once consumed, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            bundle_r    <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            bundle_r    <= bundle_next_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid   = out_valid_r;
    assign out_imm     = bundle_r.imm;
    assign out_funct3  = bundle_r.funct3;
    assign out_funct7  = bundle_r.funct7;
    assign out_rs1     = bundle_r.rs1;
    assign out_rs2     = bundle_r.rs2;
    assign out_rd      = bundle_r.rd;
    assign out_illegal = bundle_r.illegal;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Bench for operand_issue_stage: directed scenarios then randomized traffic,
// all checked against a register/busy-array reference model.
module tb_operand_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_imm;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_rs1;
    logic [31:0] out_rs2;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = 5'd0;
    logic [31:0] wb_data = 32'd0;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_regs [32];
    bit   [31:0] m_busy;
    bit          m_valid;
    logic [80:0] m_b;

    operand_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_illegal(out_illegal), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [80:0] dut_bundle();
        return {out_imm, out_funct3, out_funct7, out_rs1, out_rs2, out_rd, out_illegal};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_busy  = '0;
        m_valid = 1'b0;
        m_b     = '0;
    endtask

    function automatic bit still_busy(input logic [4:0] r);
        return m_busy[r] && !(wb_en && wb_addr == r);
    endfunction

    function automatic logic [31:0] src_val(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_en && wb_addr == r) return wb_data;
        return m_regs[r];
    endfunction

    task automatic drive(input bit v, input logic [31:0] ins, input bit we,
                         input logic [4:0] wa, input logic [31:0] wd, input bit ordy);
        in_valid = v; in_instr = ins; wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    endtask

    // One clock: check in_ready, clock the model alongside the DUT, check the bundle
    task automatic cycle();
        logic [6:0]  opc;
        logic [4:0]  r1, r2, rd;
        bit          is_op, is_imm, hz, exp_rdy, acc;
        logic [80:0] nb;
        #1;
        opc    = in_instr[6:0];
        rd     = in_instr[11:7];
        r1     = in_instr[19:15];
        r2     = in_instr[24:20];
        is_op  = (opc == 7'h33);
        is_imm = (opc == 7'h13);
        hz     = (is_op || is_imm) &&
                 (still_busy(r1) || (is_op && still_busy(r2)) || still_busy(rd));
        exp_rdy = (!m_valid || out_ready) && !hz;
        check("in_ready", {127'd0, in_ready}, {127'd0, exp_rdy});
        acc = in_valid && exp_rdy;
        if (is_op || is_imm)
            nb = {is_imm, in_instr[14:12], in_instr[31:25], src_val(r1),
                  is_imm ? {{20{in_instr[31]}}, in_instr[31:20]} : src_val(r2), rd, 1'b0};
        else
            nb = {1'b0, in_instr[14:12], in_instr[31:25], 32'd0, 32'd0, 5'd0, 1'b1};
        @(posedge clk);
        if (acc) begin
            m_valid = 1'b1;
            m_b     = nb;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (wb_en) begin
            if (wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
            m_busy[wb_addr] = 1'b0;
        end
        if (acc && (is_op || is_imm) && rd != 5'd0) m_busy[rd] = 1'b1;
        #1;
        check("out_valid", {127'd0, out_valid}, {127'd0, m_valid});
        if (m_valid) check("bundle", {47'd0, dut_bundle()}, {47'd0, m_b});
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ins;
        logic [4:0]  wa;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_outputs", {46'd0, out_valid, dut_bundle()}, 128'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        @(negedge clk);

        // Load x1=5, x2=3, then add x3,x1,x2
        drive(1'b0, 32'd0, 1'b1, 5'd1, 32'd5, 1'b1); cycle();
        drive(1'b0, 32'd0, 1'b1, 5'd2, 32'd3, 1'b1); cycle();
        drive(1'b1, 32'h002081B3, 1'b0, 5'd0, 32'd0, 1'b1); cycle();
        check("add_fields", {47'd0, dut_bundle()},
              {47'd0, 1'b0, 3'd0, 7'd0, 32'd5, 32'd3, 5'd3, 1'b0});

        // Dependent sub x5,x3,x1 stalls until x3 is written back
        drive(1'b1, 32'h401182B3, 1'b0, 5'd0, 32'd0, 1'b1); cycle();
        check("raw_stall", {127'd0, in_ready}, 128'd0);
        cycle();
        drive(1'b1, 32'h401182B3, 1'b1, 5'd3, 32'd8, 1'b1); cycle();
        check("raw_bypass_rs1", {96'd0, out_rs1}, 128'd8);
        check("raw_rd", {123'd0, out_rd}, 128'd5);

        // srai x4,x1,3 keeps funct7 bits inside the immediate
        drive(1'b1, 32'h4030D213, 1'b0, 5'd0, 32'd0, 1'b1); cycle();
        check("srai_fields", {47'd0, dut_bundle()},
              {47'd0, 1'b1, 3'd5, 7'h20, 32'd5, 32'h00000403, 5'd4, 1'b0});

        // Backpressure: addi x6,x1,7 waits three cycles behind the held srai bundle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00708313, 1'b0, 5'd0, 32'd0, 1'b0); cycle();
            check("hold_rs2", {96'd0, out_rs2}, 128'h403);
        end
        drive(1'b1, 32'h00708313, 1'b0, 5'd0, 32'd0, 1'b1); cycle();
        check("release_addi", {96'd0, out_rs2, 5'd6}, {96'd0, 32'd7, 5'd6} >> 0);

        // Load opcode is illegal and must not mark x3 busy
        drive(1'b1, 32'h0000A183, 1'b0, 5'd0, 32'd0, 1'b1); cycle();
        check("illegal", {120'd0, out_illegal, out_rd, out_rs1[1:0]}, {120'd0, 1'b1, 5'd0, 2'd0});
        drive(1'b1, 32'h000184B3, 1'b0, 5'd0, 32'd0, 1'b1); cycle();
        check("x3_not_busy", {96'd0, out_rs1}, 128'd8);
        drive(1'b0, 32'd0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1); cycle();
        drive(1'b1, 32'h000003B3, 1'b0, 5'd0, 32'd0, 1'b1); cycle();
        check("x0_zero", {64'd0, out_rs1, out_rs2}, 128'd0);

        // Reset in the middle of a RAW stall
        drive(1'b1, 32'h002081B3, 1'b1, 5'd7, 32'd1, 1'b1); cycle();
        drive(1'b1, 32'h401182B3, 1'b0, 5'd0, 32'd0, 1'b1);
        #1;
        check("pre_rst_stall", {127'd0, in_ready}, 128'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {46'd0, out_valid, dut_bundle()}, 128'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("post_rst_accept", {95'd0, out_valid, out_rs1}, {95'd0, 1'b1, 32'd0});

        // Randomized traffic over x0..x7
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: ins[6:0] = 7'h33;
                1: ins[6:0] = 7'h13;
                2: ins[6:0] = 7'h03;
                default: ins[6:0] = 7'($urandom);
            endcase
            wa = 5'($urandom_range(0, 7));
            for (int k = 0; k < 8; k++) begin
                if (m_busy[(wa + k) % 8]) begin
                    wa = 5'((wa + k) % 8);
                    break;
                end
            end
            drive($urandom_range(0, 9) < 8, ins, $urandom_range(0, 1) == 1, wa,
                  $urandom, $urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
